// File: rtl/xform_arbiter.sv
// xform_arbiter: round-robin luma/chroma access to one transform, burst out then wait for feedback
module xform_arbiter #(
  parameter int BURST     = 4,
  parameter int FBTIMEOUT = 255
) (
  input  logic        CLK2,
  input  logic        NEWLINE,
  input  logic        REQ_L,
  input  logic        REQ_C,
  input  logic [35:0] DATA_L,
  input  logic [35:0] DATA_C,
  input  logic        XF_READY,
  input  logic        FBSTROBE,
  output logic        GNT_L,
  output logic        GNT_C,
  output logic        ACK_L,
  output logic        ACK_C,
  output logic        DONE_L,
  output logic        DONE_C,
  output logic        XF_STROBE,
  output logic [35:0] XF_DATA,
  output logic        XF_SRC,
  output logic        ERR
);
  localparam logic [1:0] IDLE = 2'd0, XFER = 2'd1, WAITFB = 2'd2, DONE = 2'd3;
  logic [1:0] state;
  logic [3:0] cnt;
  logic [7:0] tmo;
  logic       last;
  logic       win_c;
  // last=1 means chroma was served last, so luma wins a tie
  assign win_c = REQ_C & (~REQ_L | ~last);
  always_comb begin
    XF_STROBE = (state == XFER) & XF_READY;
    ACK_L     = XF_STROBE & ~XF_SRC;
    ACK_C     = XF_STROBE & XF_SRC;
    XF_DATA   = (state == XFER) ? (XF_SRC ? DATA_C : DATA_L) : '0;
    DONE_L    = (state == DONE) & ~XF_SRC;
    DONE_C    = (state == DONE) & XF_SRC;
  end
  always_ff @(posedge CLK2) begin
    if (NEWLINE) begin
      state  <= IDLE;
      cnt    <= '0;
      tmo    <= '0;
      last   <= 1'b1;
      XF_SRC <= 1'b0;
      GNT_L  <= 1'b0;
      GNT_C  <= 1'b0;
      ERR    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (FBSTROBE) ERR <= 1'b1;
          if (REQ_L | REQ_C) begin
            XF_SRC <= win_c;
            GNT_L  <= ~win_c;
            GNT_C  <= win_c;
            cnt    <= '0;
            state  <= XFER;
          end
        end
        XFER: begin
          if (FBSTROBE) ERR <= 1'b1;
          if (XF_STROBE) begin
            cnt <= cnt + 4'd1;
            if (cnt + 4'd1 == 4'(BURST)) begin
              state <= WAITFB;
              tmo   <= '0;
            end
          end
        end
        WAITFB: begin
          // feedback wins over a timeout landing on the same edge
          if (FBSTROBE) state <= DONE;
          else begin
            tmo <= tmo + 8'd1;
            if (tmo + 8'd1 == 8'(FBTIMEOUT)) begin
              ERR   <= 1'b1;
              state <= DONE;
            end
          end
        end
        default: begin
          GNT_L <= 1'b0;
          GNT_C <= 1'b0;
          last  <= XF_SRC;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_xform_arbiter.sv
// tb_xform_arbiter: transaction-level model of round-robin grants, bursts and feedback wait
module tb_xform_arbiter;
  localparam int BURST = 4;
  localparam int FBT   = 255;
  logic        clk = 1'b0;
  logic        NEWLINE, REQ_L, REQ_C, XF_READY, FBSTROBE;
  logic [35:0] DATA_L, DATA_C, XF_DATA;
  logic        GNT_L, GNT_C, ACK_L, ACK_C, DONE_L, DONE_C, XF_STROBE, XF_SRC, ERR;
  int          errors = 0;
  int          checks = 0;
  bit          m_last;
  bit          m_err;
  int          acks;

  always #5 clk = ~clk;

  xform_arbiter #(.BURST(BURST), .FBTIMEOUT(FBT)) dut (
    .CLK2(clk), .NEWLINE(NEWLINE), .REQ_L(REQ_L), .REQ_C(REQ_C),
    .DATA_L(DATA_L), .DATA_C(DATA_C), .XF_READY(XF_READY), .FBSTROBE(FBSTROBE),
    .GNT_L(GNT_L), .GNT_C(GNT_C), .ACK_L(ACK_L), .ACK_C(ACK_C),
    .DONE_L(DONE_L), .DONE_C(DONE_C), .XF_STROBE(XF_STROBE), .XF_DATA(XF_DATA),
    .XF_SRC(XF_SRC), .ERR(ERR)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) check("gnt_exclusive", 64'(GNT_L & GNT_C), 64'd0);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [35:0] r36();
    logic [63:0] v;
    v = {$urandom, $urandom};
    return v[35:0];
  endfunction

  task automatic do_reset();
    NEWLINE = 1'b1;
    step();
    NEWLINE = 1'b0;
    m_last = 1'b1;
    m_err = 1'b0;
  endtask

  // fb < FBT: feedback after fb idle cycles in WAITFB; fb >= FBT: never send feedback
  // mode 0: random ready, 1: always ready, 2: ready alternating 1,0,...
  task automatic do_txn(input bit rl, input bit rc, input int fb, input int mode, input bit drop);
    bit ec;
    bit rdy;
    int words;
    int n;
    REQ_L = rl;
    REQ_C = rc;
    FBSTROBE = 1'b0;
    XF_READY = 1'b1;
    DATA_L = r36();
    DATA_C = r36();
    #1;
    check("idle_strobe", 64'(XF_STROBE), 64'd0);
    check("idle_data", 64'(XF_DATA), 64'd0);
    check("idle_gnt", 64'({GNT_L, GNT_C}), 64'd0);
    ec = rc && (!rl || !m_last);
    step();
    check("grant_l", 64'(GNT_L), 64'(!ec));
    check("grant_c", 64'(GNT_C), 64'(ec));
    check("xf_src", 64'(XF_SRC), 64'(ec));
    if (drop) begin
      REQ_L = 1'($urandom);
      REQ_C = 1'($urandom);
    end
    words = 0;
    n = 0;
    acks = 0;
    while (words < BURST && n < 200) begin
      rdy = (mode == 1) ? 1'b1 : (mode == 2) ? (n % 2 == 0) : 1'($urandom);
      XF_READY = rdy;
      DATA_L = r36();
      DATA_C = r36();
      #1;
      check("xf_strobe", 64'(XF_STROBE), 64'(rdy));
      check("ack_l", 64'(ACK_L), 64'(rdy && !ec));
      check("ack_c", 64'(ACK_C), 64'(rdy && ec));
      check("xf_data", 64'(XF_DATA), 64'(ec ? DATA_C : DATA_L));
      acks += ec ? int'(ACK_C) : int'(ACK_L);
      words += int'(rdy);
      n++;
      step();
    end
    check("ack_total", 64'(acks), 64'(BURST));
    XF_READY = 1'b1;
    #1;
    check("waitfb_strobe", 64'(XF_STROBE), 64'd0);
    check("waitfb_data", 64'(XF_DATA), 64'd0);
    for (int i = 0; i < fb && i < FBT - 1; i++) begin
      check("wait_done", 64'({DONE_L, DONE_C}), 64'd0);
      check("wait_err", 64'(ERR), 64'(m_err));
      step();
    end
    FBSTROBE = (fb < FBT);
    step();
    FBSTROBE = 1'b0;
    if (fb >= FBT) m_err = 1'b1;
    check("done_err", 64'(ERR), 64'(m_err));
    check("done_l", 64'(DONE_L), 64'(!ec));
    check("done_c", 64'(DONE_C), 64'(ec));
    check("done_gnt", 64'({GNT_L, GNT_C}), 64'({!ec, ec}));
    step();
    check("after_done", 64'({DONE_L, DONE_C}), 64'd0);
    check("after_gnt", 64'({GNT_L, GNT_C}), 64'd0);
    m_last = ec;
  endtask

  initial begin
    REQ_L = 0; REQ_C = 0; XF_READY = 1; FBSTROBE = 0; DATA_L = '0; DATA_C = '0; NEWLINE = 0;
    do_reset();
    check("rst_gnt", 64'({GNT_L, GNT_C}), 64'd0);
    check("rst_done", 64'({DONE_L, DONE_C}), 64'd0);
    check("rst_err", 64'(ERR), 64'd0);
    check("rst_src", 64'(XF_SRC), 64'd0);
    check("rst_strobe", 64'(XF_STROBE), 64'd0);
    // tie after reset goes to luma, then chroma
    do_txn(1, 1, 3, 1, 0);
    do_txn(1, 1, 2, 1, 0);
    // chroma alone with ready toggling
    do_txn(0, 1, 1, 2, 0);
    // feedback never returns
    do_txn(1, 0, FBT, 0, 0);
    // feedback in IDLE is an error but nothing else
    do_reset();
    REQ_L = 0; REQ_C = 0; FBSTROBE = 1;
    step();
    FBSTROBE = 0;
    check("idle_fb_err", 64'(ERR), 64'd1);
    check("idle_fb_gnt", 64'({GNT_L, GNT_C}), 64'd0);
    check("idle_fb_done", 64'({DONE_L, DONE_C}), 64'd0);
    step();
    check("idle_fb_stay", 64'({GNT_L, GNT_C, DONE_L, DONE_C, XF_STROBE}), 64'd0);
    m_err = 1'b1;
    // feedback on the timeout edge counts as feedback
    do_reset();
    do_txn(1, 0, FBT - 1, 0, 0);
    // reset abandons a chroma burst after two words
    do_reset();
    REQ_L = 0; REQ_C = 1; XF_READY = 1;
    step();
    check("abort_gnt", 64'(GNT_C), 64'd1);
    step();
    step();
    NEWLINE = 1'b1;
    step();
    NEWLINE = 1'b0;
    m_last = 1'b1;
    m_err = 1'b0;
    check("abort_gnt_c", 64'(GNT_C), 64'd0);
    check("abort_done", 64'(DONE_C), 64'd0);
    check("abort_err", 64'(ERR), 64'd0);
    check("abort_strobe", 64'(XF_STROBE), 64'd0);
    do_txn(1, 1, 0, 1, 0);
    // sustained contention alternates owners
    for (int k = 0; k < 6; k++) do_txn(1, 1, $urandom_range(0, 5), 0, 0);
    for (int k = 0; k < 25; k++) begin
      bit rl;
      bit rc;
      rl = 1'($urandom);
      rc = rl ? 1'($urandom) : 1'b1;
      do_txn(rl, rc, ($urandom_range(0, 7) == 0) ? FBT : $urandom_range(0, 12), 0, 1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
